// File: rtl/spi_burst_tx.sv
// SPI master transmitter with a write FIFO; one start pulse sends up to BURST_LEN
// queued words inside a single chip-select frame.
module spi_burst_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CLK_DIV    = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                               CLKA,
  input  logic                               rst,
  input  logic                               start,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               mosi,
  output logic                               spi_clk,
  output logic                               cs_n,
  output logic                               spi_ready,
  output logic [$clog2(BURST_LEN+1)-1:0]     words_sent
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WS_W  = $clog2(BURST_LEN + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [WS_W-1:0]  WS_MAX   = WS_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_END
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_next;
  logic              full;
  logic              empty;
  logic              do_wr;
  logic              do_rd;
  logic [DATA_W-1:0] head;

  logic [DATA_W-1:0] shreg;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WS_W-1:0]   ws_inc;
  logic              div_hit;
  logic              lead_edge;
  logic              trail_edge;
  logic              last_trail;
  logic              more_words;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  // Handshake: a word transfers on any CLKA edge where wr_valid && wr_ready;
  // wr_ready depends only on registered fullness, never on wr_valid or a same-cycle pop.
  assign wr_ready = !full;
  assign do_wr    = wr_valid && !full;
  assign empty    = (fifo_level == '0);
  assign head     = mem[rd_ptr];

  assign div_hit    = (div_cnt == DIV_LAST);
  assign lead_edge  = (state == S_SHIFT) && div_hit && (spi_clk == CPOL);
  assign trail_edge = (state == S_SHIFT) && div_hit && (spi_clk != CPOL);
  assign last_trail = trail_edge && (bit_cnt == BIT_LAST);
  assign ws_inc     = words_sent + 1'b1;
  assign more_words = (ws_inc < WS_MAX) && !empty;
  assign do_rd      = (state == S_LOAD) || (last_trail && more_words);

  always_comb begin
    level_next = fifo_level;
    if (do_wr && !do_rd) begin
      level_next = fifo_level + 1'b1;
    end else if (!do_wr && do_rd) begin
      level_next = fifo_level - 1'b1;
    end
  end

  always_ff @(posedge CLKA or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      full       <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_next;
      full       <= (level_next == LVL_FULL);
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge CLKA) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLKA or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      mosi       <= 1'b0;
      spi_clk    <= CPOL;
      cs_n       <= 1'b1;
      spi_ready  <= 1'b1;
      words_sent <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !empty) begin
            words_sent <= '0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg     <= head;
          mosi      <= first_bit(head);
          cs_n      <= 1'b0;
          spi_ready <= 1'b0;
          spi_clk   <= CPOL;
          div_cnt   <= '0;
          bit_cnt   <= '0;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_hit) begin
            div_cnt <= '0;
            spi_clk <= ~spi_clk;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (lead_edge && CPHA) begin
            mosi  <= first_bit(shreg);
            shreg <= shift_word(shreg);
          end
          if (trail_edge) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt    <= '0;
              words_sent <= ws_inc;
              if (more_words) begin
                // Back-to-back word; with CPHA=1 mosi waits for the next leading edge.
                shreg <= head;
                if (!CPHA) mosi <= first_bit(head);
              end else begin
                state <= S_END;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              if (!CPHA) begin
                mosi  <= first_bit(shift_word(shreg));
                shreg <= shift_word(shreg);
              end
            end
          end
        end
        S_END: begin
          if (div_hit) begin
            div_cnt   <= '0;
            cs_n      <= 1'b1;
            spi_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_tx.sv
// Bench for spi_burst_tx: a mode-0 MSB-first instance and a mode-3 LSB-first instance,
// serial words decoded on spi_clk rising edges and matched against an expected queue.
module tb_spi_burst_tx;

  localparam int DIV_A = 2;
  localparam int DIV_B = 3;

  logic CLKA = 1'b0;
  logic rst  = 1'b0;

  logic       a_start = 1'b0, a_wr_valid = 1'b0, a_wr_ready;
  logic [7:0] a_wr_data = '0;
  logic [3:0] a_fifo_level;
  logic [1:0] a_words_sent;
  logic       a_mosi, a_spi_clk, a_cs_n, a_spi_ready;

  logic       b_start = 1'b0, b_wr_valid = 1'b0, b_wr_ready;
  logic [7:0] b_wr_data = '0;
  logic [2:0] b_fifo_level;
  logic [2:0] b_words_sent;
  logic       b_mosi, b_spi_clk, b_cs_n, b_spi_ready;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 CLKA = ~CLKA;

  spi_burst_tx #(
    .DATA_W(8), .FIFO_DEPTH(8), .BURST_LEN(2), .CLK_DIV(DIV_A),
    .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)
  ) dut_a (
    .CLKA(CLKA), .rst(rst), .start(a_start), .wr_data(a_wr_data), .wr_valid(a_wr_valid),
    .wr_ready(a_wr_ready), .fifo_level(a_fifo_level), .mosi(a_mosi), .spi_clk(a_spi_clk),
    .cs_n(a_cs_n), .spi_ready(a_spi_ready), .words_sent(a_words_sent)
  );

  spi_burst_tx #(
    .DATA_W(8), .FIFO_DEPTH(4), .BURST_LEN(4), .CLK_DIV(DIV_B),
    .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)
  ) dut_b (
    .CLKA(CLKA), .rst(rst), .start(b_start), .wr_data(b_wr_data), .wr_valid(b_wr_valid),
    .wr_ready(b_wr_ready), .fifo_level(b_fifo_level), .mosi(b_mosi), .spi_clk(b_spi_clk),
    .cs_n(b_cs_n), .spi_ready(b_spi_ready), .words_sent(b_words_sent)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  logic [7:0] acc_a = '0, acc_b = '0;
  int nb_a = 0, nb_b = 0;
  logic pa_clk = 1'b0, pa_cs = 1'b1, pa_mosi = 1'b0;
  logic pb_clk = 1'b1, pb_cs = 1'b1, pb_mosi = 1'b0;

  initial forever begin
    @(negedge CLKA);
    if (rst) begin
      nb_a = 0; acc_a = '0;
      nb_b = 0; acc_b = '0;
    end else begin
      if (!pa_cs && a_mosi !== pa_mosi) check("a mosi changes on falling edge", {pa_clk, a_spi_clk}, 2'b10);
      if (a_spi_clk && !pa_clk) begin
        acc_a = {acc_a[6:0], a_mosi};
        nb_a++;
        if (nb_a == 8) begin
          nb_a = 0;
          if (exp_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL a unexpected word: got %0h expected none", acc_a);
          end else begin
            check("a serial word", acc_a, exp_a.pop_front());
          end
        end
      end
      if (!pb_cs && b_mosi !== pb_mosi) check("b mosi changes on falling edge", {pb_clk, b_spi_clk}, 2'b10);
      if (b_spi_clk && !pb_clk) begin
        acc_b = {b_mosi, acc_b[7:1]};
        nb_b++;
        if (nb_b == 8) begin
          nb_b = 0;
          if (exp_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL b unexpected word: got %0h expected none", acc_b);
          end else begin
            check("b serial word", acc_b, exp_b.pop_front());
          end
        end
      end
    end
    pa_clk = a_spi_clk; pa_cs = a_cs_n; pa_mosi = a_mosi;
    pb_clk = b_spi_clk; pb_cs = b_cs_n; pb_mosi = b_mosi;
  end

  // ---------------- drivers ----------------
  task automatic write_word(input int sel, input logic [7:0] d);
    bit done = 0;
    @(negedge CLKA);
    if (sel != 0) begin b_wr_valid = 1'b1; b_wr_data = d; end
    else begin a_wr_valid = 1'b1; a_wr_data = d; end
    for (int i = 0; i < 300 && !done; i++) begin
      if ((sel != 0) ? b_wr_ready : a_wr_ready) begin
        if (sel != 0) exp_b.push_back(d); else exp_a.push_back(d);
        done = 1;
      end
      @(negedge CLKA);
    end
    a_wr_valid = 1'b0;
    b_wr_valid = 1'b0;
    if (!done) check("write accepted", 0, 1);
  endtask

  task automatic run_burst(input int sel, input int exp_n, input int exp_sent, input int exp_level);
    int div, first_low, first_lead, rise_k, rdy_k, rises;
    bit rdy_dropped;
    logic cpol_v, pclk, prdy, cs, clk, rdy;
    div = (sel != 0) ? DIV_B : DIV_A;
    cpol_v = (sel != 0);
    first_low = -1; first_lead = -1; rise_k = -1; rdy_k = -1; rises = 0; rdy_dropped = 0;
    @(negedge CLKA);
    if (sel != 0) b_start = 1'b1; else a_start = 1'b1;
    @(negedge CLKA);
    a_start = 1'b0;
    b_start = 1'b0;
    pclk = cpol_v;
    prdy = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (k > 0) @(negedge CLKA);
      cs  = (sel != 0) ? b_cs_n : a_cs_n;
      clk = (sel != 0) ? b_spi_clk : a_spi_clk;
      rdy = (sel != 0) ? b_spi_ready : a_spi_ready;
      if (!cs && first_low < 0) first_low = k;
      if (cs && first_low >= 0 && rise_k < 0) rise_k = k;
      if (clk !== cpol_v && first_lead < 0) first_lead = k;
      if (clk && !pclk) rises++;
      if (!rdy) rdy_dropped = 1;
      if (rdy && !prdy && rdy_k < 0) rdy_k = k;
      pclk = clk;
      prdy = rdy;
      if (rise_k >= 0 || (exp_n == 0 && k >= 100)) break;
    end
    if (exp_n == 0) begin
      check("ignored start cs_n activity", first_low, -1);
      check("ignored start spi_ready dropped", {31'd0, rdy_dropped}, 0);
      check("ignored start spi_clk edges", rises, 0);
    end else begin
      check("cs_n low cycle", first_low, 1);
      check("first leading edge cycle", first_lead, 1 + div);
      check("cs_n high cycle", rise_k, 1 + 2 * div * 8 * exp_n + div);
      check("spi_ready rise cycle", rdy_k, 1 + 2 * div * 8 * exp_n + div);
      check("spi_clk rising edges", rises, 8 * exp_n);
    end
    check("words_sent", (sel != 0) ? 32'(b_words_sent) : 32'(a_words_sent), exp_sent);
    check("fifo_level", (sel != 0) ? 32'(b_fifo_level) : 32'(a_fifo_level), exp_level);
  endtask

  // ---------------- vector table for the mode-0 instance ----------------
  typedef struct packed {
    logic [1:0]      nwr;
    logic [2:0][7:0] w;
    logic [1:0]      exp_n;
    logic [1:0]      exp_sent;
    logic [3:0]      exp_level;
  } vec_t;

  function automatic vec_t mk_vec(input int nwr, input logic [7:0] w0, input logic [7:0] w1,
                                  input logic [7:0] w2, input int n, input int sent, input int lvl);
    vec_t v;
    v.nwr = 2'(nwr);
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.exp_n = 2'(n);
    v.exp_sent = 2'(sent);
    v.exp_level = 4'(lvl);
    return v;
  endfunction

  vec_t vecs [6];
  logic [7:0] full_words [9];
  int rises;
  int bad;
  logic prev;
  bit seen;

  initial begin
    vecs[0] = mk_vec(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    vecs[1] = mk_vec(2, 8'hA5, 8'h3C, 8'h00, 2, 2, 0);
    vecs[2] = mk_vec(3, 8'h11, 8'h22, 8'h33, 2, 2, 1);
    vecs[3] = mk_vec(0, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    vecs[4] = mk_vec(1, 8'($urandom_range(0, 255)), 8'h00, 8'h00, 1, 1, 0);
    vecs[5] = mk_vec(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    for (int i = 0; i < 9; i++) full_words[i] = 8'($urandom_range(0, 255));

    // ---- reset asserted mid-cycle ----
    #3 rst = 1'b1;
    #1;
    check("a rst mosi", a_mosi, 0);
    check("a rst spi_clk", a_spi_clk, 0);
    check("a rst cs_n", a_cs_n, 1);
    check("a rst spi_ready", a_spi_ready, 1);
    check("a rst wr_ready", a_wr_ready, 1);
    check("a rst fifo_level", a_fifo_level, 0);
    check("a rst words_sent", a_words_sent, 0);
    check("b rst spi_clk", b_spi_clk, 1);
    check("b rst cs_n", b_cs_n, 1);
    check("b rst spi_ready", b_spi_ready, 1);
    check("b rst fifo_level", b_fifo_level, 0);
    repeat (3) @(negedge CLKA);
    rst = 1'b0;

    // ---- table-driven bursts ----
    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < int'(vecs[v].nwr); j++) write_word(0, vecs[v].w[j]);
      run_burst(0, int'(vecs[v].exp_n), int'(vecs[v].exp_sent), int'(vecs[v].exp_level));
    end

    // ---- word written during a burst joins it ----
    write_word(0, 8'h6B);
    fork
      run_burst(0, 2, 2, 0);
      begin
        repeat (10) @(negedge CLKA);
        write_word(0, 8'hD2);
      end
    join

    // ---- FIFO full, held write accepted after LOAD ----
    @(negedge CLKA);
    a_wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_wr_data = full_words[i];
      check("fill wr_ready", a_wr_ready, 1);
      exp_a.push_back(full_words[i]);
      @(negedge CLKA);
    end
    a_wr_data = full_words[8];
    check("full wr_ready", a_wr_ready, 0);
    check("full fifo_level", a_fifo_level, 8);
    repeat (3) @(negedge CLKA);
    check("full held wr_ready", a_wr_ready, 0);
    a_start = 1'b1;
    @(negedge CLKA);
    a_start = 1'b0;
    check("wr_ready during LOAD", a_wr_ready, 0);
    @(negedge CLKA);
    check("wr_ready after LOAD", a_wr_ready, 1);
    exp_a.push_back(full_words[8]);
    @(negedge CLKA);
    a_wr_valid = 1'b0;
    check("level after 9th accept", a_fifo_level, 8);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge CLKA);
      if (a_spi_ready) seen = 1;
    end
    check("full burst completes", {31'd0, seen}, 1);
    check("full burst words_sent", a_words_sent, 2);
    check("full burst fifo_level", a_fifo_level, 7);
    run_burst(0, 2, 2, 5);
    run_burst(0, 2, 2, 3);
    run_burst(0, 2, 2, 1);
    run_burst(0, 1, 1, 0);

    // ---- mode 3, LSB first ----
    check("b spi_clk idles high", b_spi_clk, 1);
    write_word(1, 8'h81);
    run_burst(1, 1, 1, 0);
    write_word(1, 8'h1E);
    write_word(1, 8'h5A);
    run_burst(1, 2, 2, 0);

    // ---- reset mid-burst ----
    write_word(0, 8'hC3);
    write_word(0, 8'h96);
    @(negedge CLKA);
    a_start = 1'b1;
    @(negedge CLKA);
    a_start = 1'b0;
    rises = 0;
    prev = a_spi_clk;
    for (int i = 0; i < 300 && rises < 3; i++) begin
      @(negedge CLKA);
      if (a_spi_clk && !prev) rises++;
      prev = a_spi_clk;
    end
    check("abort reached third bit", rises, 3);
    #2 rst = 1'b1;
    exp_a.delete();
    #1;
    check("abort cs_n", a_cs_n, 1);
    check("abort spi_clk", a_spi_clk, 0);
    check("abort spi_ready", a_spi_ready, 1);
    check("abort mosi", a_mosi, 0);
    check("abort fifo_level", a_fifo_level, 0);
    check("abort words_sent", a_words_sent, 0);
    repeat (2) @(negedge CLKA);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLKA);
      if (a_spi_clk !== 1'b0 || a_cs_n !== 1'b1) bad++;
    end
    check("post abort idle", bad, 0);
    check("post abort fifo_level", a_fifo_level, 0);

    check("a queue drained", exp_a.size(), 0);
    check("b queue drained", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
